// File: rtl/gj_axis_uart_regs.sv
// Host register block for the AXIS UART core: configuration, timed soft reset,
// sticky error flags and saturating traffic counters behind a 16-word BRAM port.
module gj_axis_uart_regs #(
  parameter logic [15:0] DIV_DEFAULT  = 16'd27,
  parameter logic [3:0]  MODE_DEFAULT = 4'b0001,
  parameter int          RST_CYCLES   = 16,
  parameter logic [31:0] ID_VALUE     = 32'h4741_5501
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bram_en,
  input  logic [3:0]  bram_addr,
  input  logic [3:0]  bram_we,
  input  logic [31:0] bram_wdata,
  output logic [31:0] bram_rdata,
  output logic        softRst,
  output logic        powerDown,
  output logic [15:0] clkDivX16,
  output logic [3:0]  mode,
  output logic [15:0] tx_nop,
  input  logic        tx_tvalid,
  input  logic        tx_tready,
  input  logic        rx_tvalid,
  input  logic        rx_tuser,
  input  logic        startError
);

  localparam logic [15:0] RST_LOAD = 16'(RST_CYCLES - 1);

  localparam logic [3:0] A_CTRL   = 4'h0;
  localparam logic [3:0] A_BAUD   = 4'h1;
  localparam logic [3:0] A_TXNOP  = 4'h2;
  localparam logic [3:0] A_STATUS = 4'h3;
  localparam logic [3:0] A_RXCNT  = 4'h4;
  localparam logic [3:0] A_TXCNT  = 4'h5;
  localparam logic [3:0] A_ERRCNT = 4'h6;
  localparam logic [3:0] A_ID     = 4'hF;

  typedef enum logic {
    IDLE,
    HOLD
  } srst_state_t;

  srst_state_t state, state_d;
  logic [15:0] rst_cnt, rst_cnt_d;

  logic        start_sticky, crc_sticky;
  logic [15:0] rx_cnt, rx_crc_cnt, tx_cnt, err_cnt;
  logic [31:0] rd_mux;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [15:0] merge16(input logic [15:0] cur,
                                          input logic [1:0]  we,
                                          input logic [15:0] wd);
    logic [15:0] r;
    r = cur;
    if (we[0]) r[7:0]  = wd[7:0];
    if (we[1]) r[15:8] = wd[15:8];
    return r;
  endfunction

  // Access decode
  logic wr, rd;
  logic wr_ctrl, wr_baud, wr_txnop, wr_status, wr_rxcnt, wr_txcnt, wr_errcnt;
  logic srst_req;

  assign wr        = bram_en & (bram_we != 4'b0000);
  assign rd        = bram_en & (bram_we == 4'b0000);
  assign wr_ctrl   = wr & (bram_addr == A_CTRL);
  assign wr_baud   = wr & (bram_addr == A_BAUD);
  assign wr_txnop  = wr & (bram_addr == A_TXNOP);
  assign wr_status = wr & (bram_addr == A_STATUS);
  assign wr_rxcnt  = wr & (bram_addr == A_RXCNT);
  assign wr_txcnt  = wr & (bram_addr == A_TXCNT);
  assign wr_errcnt = wr & (bram_addr == A_ERRCNT);
  assign srst_req  = wr_ctrl & bram_we[0] & bram_wdata[0];

  // Events are ignored while the engines are held in soft reset.
  logic rx_evt, crc_evt, tx_evt, err_evt;

  assign rx_evt  = rx_tvalid & ~softRst;
  assign crc_evt = rx_tvalid & rx_tuser & ~softRst;
  assign tx_evt  = tx_tvalid & tx_tready & ~softRst;
  assign err_evt = startError & ~softRst;

  // Soft-reset sequencer
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rst_cnt <= 16'd0;
      softRst <= 1'b1;
    end else begin
      // NOTE: all clocked state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state   <= state_d;
      rst_cnt <= rst_cnt_d;
      softRst <= (state_d == HOLD);
    end
  end

  always_comb begin
    // NOTE: defaults first, so no path through this block leaves a variable
    // unassigned and infers a latch.
    state_d   = state;
    rst_cnt_d = rst_cnt;
    case (state)
      IDLE: begin
        if (srst_req) begin
          state_d   = HOLD;
          rst_cnt_d = RST_LOAD;
        end
      end
      HOLD: begin
        if (srst_req) begin
          rst_cnt_d = RST_LOAD;
        end else if (rst_cnt == 16'd0) begin
          state_d = IDLE;
        end else begin
          rst_cnt_d = rst_cnt - 16'd1;
        end
      end
    endcase
  end

  // Configuration registers survive a soft reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      clkDivX16 <= DIV_DEFAULT;
      mode      <= MODE_DEFAULT;
      tx_nop    <= 16'd0;
      powerDown <= 1'b0;
    end else begin
      if (wr_ctrl && bram_we[0]) begin
        powerDown <= bram_wdata[1];
        mode      <= bram_wdata[7:4];
      end
      if (wr_baud)  clkDivX16 <= merge16(clkDivX16, bram_we[1:0], bram_wdata[15:0]);
      if (wr_txnop) tx_nop    <= merge16(tx_nop, bram_we[1:0], bram_wdata[15:0]);
    end
  end

  // Sticky flags: a new event beats a same-cycle write-one-to-clear.
  always_ff @(posedge clk) begin
    if (rst || softRst) begin
      start_sticky <= 1'b0;
      crc_sticky   <= 1'b0;
    end else begin
      if (err_evt)
        start_sticky <= 1'b1;
      else if (wr_status && bram_we[0] && bram_wdata[0])
        start_sticky <= 1'b0;
      if (crc_evt)
        crc_sticky <= 1'b1;
      else if (wr_status && bram_we[0] && bram_wdata[1])
        crc_sticky <= 1'b0;
    end
  end

  // Counters: a clearing write beats a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || softRst) begin
      rx_cnt     <= 16'd0;
      rx_crc_cnt <= 16'd0;
      tx_cnt     <= 16'd0;
      err_cnt    <= 16'd0;
    end else begin
      if (wr_rxcnt) begin
        rx_cnt     <= 16'd0;
        rx_crc_cnt <= 16'd0;
      end else begin
        if (rx_evt)  rx_cnt     <= sat_inc(rx_cnt);
        if (crc_evt) rx_crc_cnt <= sat_inc(rx_crc_cnt);
      end
      if (wr_txcnt)    tx_cnt  <= 16'd0;
      else if (tx_evt) tx_cnt  <= sat_inc(tx_cnt);
      if (wr_errcnt)    err_cnt <= 16'd0;
      else if (err_evt) err_cnt <= sat_inc(err_cnt);
    end
  end

  always_comb begin
    rd_mux = 32'd0;
    case (bram_addr)
      A_CTRL:   rd_mux = {24'd0, mode, 2'b00, powerDown, 1'b0};
      A_BAUD:   rd_mux = {16'd0, clkDivX16};
      A_TXNOP:  rd_mux = {16'd0, tx_nop};
      A_STATUS: rd_mux = {23'd0, (state == HOLD), 6'd0, crc_sticky, start_sticky};
      A_RXCNT:  rd_mux = {rx_crc_cnt, rx_cnt};
      A_TXCNT:  rd_mux = {16'd0, tx_cnt};
      A_ERRCNT: rd_mux = {16'd0, err_cnt};
      A_ID:     rd_mux = ID_VALUE;
      default:  rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)     bram_rdata <= 32'd0;
    else if (rd) bram_rdata <= rd_mux;
  end

  logic unused_bits;
  assign unused_bits = ^{bram_wdata[31:16], bram_wdata[3:2], bram_we[3:2]};

endmodule

// File: tb/tb_gj_axis_uart_regs.sv
// Directed self-checking bench for gj_axis_uart_regs: register access, soft-reset
// timing, event capture, saturation and simultaneous-event priorities.
module tb_gj_axis_uart_regs;

  logic        clk = 1'b0;
  logic        rst;
  logic        bram_en;
  logic [3:0]  bram_addr;
  logic [3:0]  bram_we;
  logic [31:0] bram_wdata;
  logic [31:0] bram_rdata;
  logic        softRst;
  logic        powerDown;
  logic [15:0] clkDivX16;
  logic [3:0]  mode;
  logic [15:0] tx_nop;
  logic        tx_tvalid, tx_tready, rx_tvalid, rx_tuser, startError;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gj_axis_uart_regs dut (
    .clk        (clk),
    .rst        (rst),
    .bram_en    (bram_en),
    .bram_addr  (bram_addr),
    .bram_we    (bram_we),
    .bram_wdata (bram_wdata),
    .bram_rdata (bram_rdata),
    .softRst    (softRst),
    .powerDown  (powerDown),
    .clkDivX16  (clkDivX16),
    .mode       (mode),
    .tx_nop     (tx_nop),
    .tx_tvalid  (tx_tvalid),
    .tx_tready  (tx_tready),
    .rx_tvalid  (rx_tvalid),
    .rx_tuser   (rx_tuser),
    .startError (startError)
  );

  // Every task is entered and left 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [3:0] we, input logic [31:0] d);
    bram_en = 1'b1; bram_addr = a; bram_we = we; bram_wdata = d;
    step();
    bram_en = 1'b0; bram_we = 4'b0000; bram_wdata = 32'd0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    bram_en = 1'b1; bram_addr = a; bram_we = 4'b0000;
    step();
    bram_en = 1'b0;
    d = bram_rdata;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b1;
    repeat (3) step();
    checks++; if (softRst !== 1'b1) begin errors++; $display("FAIL rst_softrst got %b exp 1", softRst); end
    checks++; if (clkDivX16 !== 16'd27) begin errors++; $display("FAIL rst_div got %h exp 001b", clkDivX16); end
    checks++; if (mode !== 4'b0001) begin errors++; $display("FAIL rst_mode got %h exp 1", mode); end
    checks++; if (tx_nop !== 16'd0 || powerDown !== 1'b0) begin errors++; $display("FAIL rst_cfg got nop=%h pd=%b exp 0/0", tx_nop, powerDown); end
    checks++; if (bram_rdata !== 32'd0) begin errors++; $display("FAIL rst_rdata got %h exp 0", bram_rdata); end
    rst = 1'b0;
    step();
    checks++; if (softRst !== 1'b0) begin errors++; $display("FAIL rst_release got %b exp 0", softRst); end
    bus_read(4'h1, d);
    checks++; if (d !== 32'h0000_001B) begin errors++; $display("FAIL rd_baud got %h exp 0000001b", d); end
    bus_read(4'h0, d);
    checks++; if (d !== 32'h0000_0010) begin errors++; $display("FAIL rd_ctrl got %h exp 00000010", d); end
    bus_read(4'hF, d);
    checks++; if (d !== 32'h4741_5501) begin errors++; $display("FAIL rd_id got %h exp 47415501", d); end
    step();
    checks++; if (bram_rdata !== 32'h4741_5501) begin errors++; $display("FAIL rd_hold got %h exp 47415501", bram_rdata); end
    bus_read(4'h3, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL rd_status got %h exp 0", d); end
  endtask

  task automatic test_config();
    logic [31:0] d;
    bus_write(4'h1, 4'b0001, 32'h1234_0036);
    checks++; if (clkDivX16 !== 16'h0036) begin errors++; $display("FAIL baud_lane0 got %h exp 0036", clkDivX16); end
    bus_write(4'h1, 4'b0011, 32'h0000_0100);
    checks++; if (clkDivX16 !== 16'h0100) begin errors++; $display("FAIL baud_lane01 got %h exp 0100", clkDivX16); end
    bus_read(4'h1, d);
    checks++; if (d !== 32'h0000_0100) begin errors++; $display("FAIL rd_baud2 got %h exp 00000100", d); end
    bus_write(4'h2, 4'b1111, 32'hFFFF_ABCD);
    checks++; if (tx_nop !== 16'hABCD) begin errors++; $display("FAIL txnop got %h exp abcd", tx_nop); end
    bus_write(4'h0, 4'b0001, 32'h0000_0032);
    checks++; if (powerDown !== 1'b1 || mode !== 4'h3 || softRst !== 1'b0) begin errors++; $display("FAIL ctrl_wr got pd=%b mode=%h srst=%b exp 1/3/0", powerDown, mode, softRst); end
    bus_read(4'h0, d);
    checks++; if (d !== 32'h0000_0032) begin errors++; $display("FAIL rd_ctrl2 got %h exp 00000032", d); end
    bus_write(4'h0, 4'b0010, 32'h0000_FF00);
    checks++; if (powerDown !== 1'b1 || mode !== 4'h3) begin errors++; $display("FAIL ctrl_lane1 got pd=%b mode=%h exp 1/3", powerDown, mode); end
    bus_write(4'h7, 4'b1111, 32'hFFFF_FFFF);
    bus_read(4'h7, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL rd_unmapped got %h exp 0", d); end
    bus_write(4'hF, 4'b1111, 32'h0);
    bus_read(4'hF, d);
    checks++; if (d !== 32'h4741_5501) begin errors++; $display("FAIL id_ro got %h exp 47415501", d); end
  endtask

  task automatic test_soft_reset();
    logic [31:0] d;
    rx_tvalid = 1'b1; startError = 1'b1;
    step();
    startError = 1'b0;
    step();
    rx_tvalid = 1'b0;
    bus_read(4'h4, d);
    checks++; if (d !== 32'h0000_0002) begin errors++; $display("FAIL pre_rxcnt got %h exp 00000002", d); end
    bram_en = 1'b1; bram_addr = 4'h0; bram_we = 4'b0001; bram_wdata = 32'h0000_0033;
    step();
    bram_addr = 4'h3; bram_we = 4'b0000; bram_wdata = 32'd0;
    for (int i = 1; i <= 20; i++) begin
      checks++; if (softRst !== (i <= 16)) begin errors++; $display("FAIL srst_len i=%0d got %b exp %b", i, softRst, (i <= 16)); end
      if (i >= 2) begin
        checks++; if (bram_rdata[8] !== (i <= 17)) begin errors++; $display("FAIL srst_busy i=%0d got %b exp %b", i, bram_rdata[8], (i <= 17)); end
      end
      rx_tvalid  = (i >= 3 && i <= 5);
      startError = (i == 4);
      step();
    end
    bram_en = 1'b0; rx_tvalid = 1'b0; startError = 1'b0;
    checks++; if (clkDivX16 !== 16'h0100 || mode !== 4'h3 || powerDown !== 1'b1 || tx_nop !== 16'hABCD) begin errors++; $display("FAIL srst_cfg got div=%h mode=%h pd=%b nop=%h exp 0100/3/1/abcd", clkDivX16, mode, powerDown, tx_nop); end
    bus_read(4'h4, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL srst_rxcnt got %h exp 0", d); end
    bus_read(4'h3, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL srst_status got %h exp 0", d); end
    bus_read(4'h6, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL srst_errcnt got %h exp 0", d); end
  endtask

  task automatic test_events();
    logic [31:0] d;
    rx_tvalid = 1'b1; rx_tuser = 1'b0; startError = 1'b1;
    step();
    rx_tuser = 1'b1; startError = 1'b0;
    step();
    rx_tuser = 1'b0;
    step();
    rx_tvalid = 1'b0;
    bus_read(4'h4, d);
    checks++; if (d !== 32'h0001_0003) begin errors++; $display("FAIL ev_rxcnt got %h exp 00010003", d); end
    bus_read(4'h6, d);
    checks++; if (d !== 32'h0000_0001) begin errors++; $display("FAIL ev_errcnt got %h exp 00000001", d); end
    bus_read(4'h3, d);
    checks++; if (d !== 32'h0000_0003) begin errors++; $display("FAIL ev_status got %h exp 00000003", d); end
    bus_read(4'h5, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL ev_txcnt got %h exp 0", d); end
    startError = 1'b1;
    bus_write(4'h3, 4'b0001, 32'h0000_0001);
    startError = 1'b0;
    bus_read(4'h3, d);
    checks++; if (d !== 32'h0000_0003) begin errors++; $display("FAIL w1c_setwins got %h exp 00000003", d); end
    bus_write(4'h3, 4'b0001, 32'h0000_0002);
    bus_read(4'h3, d);
    checks++; if (d !== 32'h0000_0001) begin errors++; $display("FAIL w1c_crc got %h exp 00000001", d); end
    bus_write(4'h3, 4'b0001, 32'h0000_0001);
    bus_read(4'h3, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL w1c_start got %h exp 0", d); end
    bus_read(4'h6, d);
    checks++; if (d !== 32'h0000_0002) begin errors++; $display("FAIL ev_errcnt2 got %h exp 00000002", d); end
    startError = 1'b1;
    bus_write(4'h6, 4'b0100, 32'd0);
    startError = 1'b0;
    bus_read(4'h6, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL clr_wins got %h exp 0", d); end
    bus_write(4'h4, 4'b1000, 32'd0);
    bus_read(4'h4, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL rxcnt_clr got %h exp 0", d); end
  endtask

  task automatic test_tx();
    logic [31:0] d;
    logic [7:0]  tv_pat, tr_pat;
    tv_pat = 8'hF7;
    tr_pat = 8'hDD;
    for (int i = 0; i < 8; i++) begin
      tx_tvalid = tv_pat[i];
      tx_tready = tr_pat[i];
      step();
    end
    tx_tvalid = 1'b0; tx_tready = 1'b0;
    bus_read(4'h5, d);
    checks++; if (d !== 32'h0000_0005) begin errors++; $display("FAIL txcnt got %h exp 00000005", d); end
    bus_write(4'h5, 4'b0001, 32'd0);
    bus_read(4'h5, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL txcnt_clr got %h exp 0", d); end
  endtask

  task automatic test_saturation();
    logic [31:0] d;
    rx_tvalid = 1'b1; rx_tuser = 1'b0;
    repeat (65540) @(posedge clk);
    #1;
    bus_read(4'h4, d);
    checks++; if (d !== 32'h0000_FFFF) begin errors++; $display("FAIL rx_sat got %h exp 0000ffff", d); end
    bus_write(4'h4, 4'b0001, 32'd0);
    rx_tvalid = 1'b0;
    bus_read(4'h4, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL rx_sat_clr got %h exp 0", d); end
  endtask

  task automatic test_back_to_back();
    bus_write(4'h0, 4'b0001, 32'h0000_0001);
    for (int i = 1; i <= 30; i++) begin
      checks++; if (softRst !== (i <= 26)) begin errors++; $display("FAIL srst_twice i=%0d got %b exp %b", i, softRst, (i <= 26)); end
      if (i == 10) begin
        bram_en = 1'b1; bram_addr = 4'h0; bram_we = 4'b0001; bram_wdata = 32'h0000_0001;
      end else begin
        bram_en = 1'b0; bram_we = 4'b0000; bram_wdata = 32'd0;
      end
      step();
    end
  endtask

  task automatic test_rst_mid_hold();
    logic [31:0] d;
    bus_write(4'h1, 4'b0011, 32'h0000_0200);
    bus_write(4'h0, 4'b0001, 32'h0000_0033);
    for (int i = 1; i <= 12; i++) begin
      checks++; if (softRst !== (i <= 8)) begin errors++; $display("FAIL rst_hold i=%0d got %b exp %b", i, softRst, (i <= 8)); end
      if (i == 5) rst = 1'b1;
      if (i == 8) rst = 1'b0;
      step();
    end
    checks++; if (clkDivX16 !== 16'd27 || mode !== 4'b0001 || powerDown !== 1'b0) begin errors++; $display("FAIL rst_hold_cfg got div=%h mode=%h pd=%b exp 001b/1/0", clkDivX16, mode, powerDown); end
    bus_read(4'h3, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL rst_hold_busy got %h exp 0", d); end
  endtask

  initial begin
    rst = 1'b1;
    bram_en = 1'b0; bram_addr = 4'h0; bram_we = 4'b0000; bram_wdata = 32'd0;
    tx_tvalid = 1'b0; tx_tready = 1'b0; rx_tvalid = 1'b0; rx_tuser = 1'b0; startError = 1'b0;
    #1;
    test_reset();
    test_config();
    test_soft_reset();
    test_events();
    test_tx();
    test_saturation();
    test_back_to_back();
    test_rst_mid_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
